// File: rtl/wfg_stim_ramp.sv
// wfg_stim_ramp: ramp stimulus generator feeding the SPI drive stage over AXI-Stream.
// Produces sawtooth (and optionally triangle) sample sequences from a shadowed
// copy of the Wishbone configuration, captured once each time the generator is
// enabled so a running ramp never sees a half-updated configuration.
//
// Build option:
//   WFG_STIM_RAMP_TRIANGLE_EN  - when defined, triangle mode and the DOWN state are
//                                compiled in and cfg_mode_q_i selects the shape.
//                                When undefined, the block always produces a
//                                sawtooth and cfg_mode_q_i is ignored.

module wfg_stim_ramp #(
    parameter int AXIS_DATA_WIDTH = 32
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       ctrl_en_q_i,
    input  logic                       cfg_mode_q_i,
    input  logic [15:0]                cfg_start_q_i,
    input  logic [15:0]                cfg_end_q_i,
    input  logic [15:0]                cfg_inc_q_i,
    input  logic                       wfg_axis_tready_i,
    output logic                       wfg_axis_tvalid_o,
    output logic [AXIS_DATA_WIDTH-1:0] wfg_axis_tdata_o,
    output logic                       wfg_axis_tlast_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    state_t      state;
    state_t      state_adv;

    // Current sample and shadowed configuration.
    logic [15:0] v;
    logic [15:0] start_s;
    logic [15:0] end_s;
    logic [15:0] inc_s;
    logic        tvalid_r;

    // Combinational view of the next step on an accepted beat.
    logic [16:0] sum17;
    logic        up_ovf;
    logic [15:0] v_adv;
    logic        tlast_c;
    logic        beat;

`ifdef WFG_STIM_RAMP_TRIANGLE_EN
    logic        mode_s;
    logic [16:0] diff17;
    logic        dn_unf;
`else
    logic        unused_mode;
    assign unused_mode = cfg_mode_q_i;
`endif

    // 17-bit arithmetic keeps v + inc from wrapping into a false "below end" result.
    assign sum17  = {1'b0, v} + {1'b0, inc_s};
    assign up_ovf = (sum17 > {1'b0, end_s});

`ifdef WFG_STIM_RAMP_TRIANGLE_EN
    // v - inc may go negative; treating the 17-bit difference as signed keeps the
    // underflow test against start correct.
    assign diff17 = {1'b0, v} - {1'b0, inc_s};
    assign dn_unf = ($signed(diff17) <= $signed({1'b0, start_s}));
`endif

    assign beat = tvalid_r && wfg_axis_tready_i;

    // Decide what the current sample means (tlast) and where an accepted beat leads.
    always_comb begin
        tlast_c   = 1'b0;
        v_adv     = v;
        state_adv = state;
        case (state)
            UP: begin
                if (up_ovf) begin
                    tlast_c = 1'b1;
                    v_adv   = start_s;
                end else begin
                    v_adv   = sum17[15:0];
                end
`ifdef WFG_STIM_RAMP_TRIANGLE_EN
                // A triangle that still has room to descend turns around instead
                // of wrapping; if it cannot descend, the period ends right here.
                if (mode_s && up_ovf && !dn_unf) begin
                    tlast_c   = 1'b0;
                    state_adv = DOWN;
                    v_adv     = diff17[15:0];
                end
`endif
            end
`ifdef WFG_STIM_RAMP_TRIANGLE_EN
            DOWN: begin
                if (dn_unf) begin
                    tlast_c   = 1'b1;
                    v_adv     = start_s;
                    state_adv = UP;
                end else begin
                    v_adv     = diff17[15:0];
                end
            end
`endif
            default: begin
                tlast_c   = 1'b0;
                v_adv     = v;
                state_adv = state;
            end
        endcase
    end

    // Main sequencer: capture config on enable, advance on accepted beats, abort on enable drop.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            v        <= 16'd0;
            start_s  <= 16'd0;
            end_s    <= 16'd0;
            inc_s    <= 16'd0;
            tvalid_r <= 1'b0;
`ifdef WFG_STIM_RAMP_TRIANGLE_EN
            mode_s   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tvalid_r <= 1'b0;
                    if (ctrl_en_q_i) begin
                        start_s  <= cfg_start_q_i;
                        end_s    <= cfg_end_q_i;
                        inc_s    <= (cfg_inc_q_i == 16'd0) ? 16'd1 : cfg_inc_q_i;
`ifdef WFG_STIM_RAMP_TRIANGLE_EN
                        mode_s   <= cfg_mode_q_i;
`endif
                        v        <= cfg_start_q_i;
                        state    <= UP;
                        tvalid_r <= 1'b1;
                    end
                end
`ifdef WFG_STIM_RAMP_TRIANGLE_EN
                UP, DOWN: begin
`else
                UP: begin
`endif
                    // Dropping enable wins over a beat accepted in the same cycle.
                    if (!ctrl_en_q_i) begin
                        state    <= IDLE;
                        tvalid_r <= 1'b0;
                    end else if (beat) begin
                        v        <= v_adv;
                        state    <= state_adv;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tvalid_r <= 1'b0;
                end
            endcase
        end
    end

    // tdata comes straight from the sample register, zero-extended to the stream width.
    always_comb begin
        wfg_axis_tdata_o       = '0;
        wfg_axis_tdata_o[15:0] = v;
    end

    assign wfg_axis_tvalid_o = tvalid_r;
    assign wfg_axis_tlast_o  = tvalid_r && tlast_c;

endmodule

// File: tb/tb_wfg_stim_ramp.sv
// tb_wfg_stim_ramp: scoreboard bench for the ramp stimulus generator.
// Expected beats are queued when a ramp is started and compared as the DUT
// hands them over; stalls, aborts and reset are checked directly.

module tb_wfg_stim_ramp;

    localparam int W = 32;

`ifdef WFG_STIM_RAMP_TRIANGLE_EN
    localparam bit TRI_EN = 1'b1;
`else
    localparam bit TRI_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         en;
    logic         mode;
    logic [15:0]  cfg_start;
    logic [15:0]  cfg_end;
    logic [15:0]  cfg_inc;
    logic         tready;
    logic         tvalid;
    logic [W-1:0] tdata;
    logic         tlast;

    int vectors     = 0;
    int miscompares = 0;

    // Each entry is {tlast, tdata[15:0]}.
    logic [16:0] exp_q[$];

    logic        stall_prev = 1'b0;
    logic [W-1:0] hold_data = '0;
    logic        hold_last  = 1'b0;

    wfg_stim_ramp #(.AXIS_DATA_WIDTH(W)) dut (
        .wb_clk_i          (clk),
        .wb_rst_i          (rst),
        .ctrl_en_q_i       (en),
        .cfg_mode_q_i      (mode),
        .cfg_start_q_i     (cfg_start),
        .cfg_end_q_i       (cfg_end),
        .cfg_inc_q_i       (cfg_inc),
        .wfg_axis_tready_i (tready),
        .wfg_axis_tvalid_o (tvalid),
        .wfg_axis_tdata_o  (tdata),
        .wfg_axis_tlast_o  (tlast)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void pushExp(input int data, input bit last);
        logic [15:0] d;
        d = data[15:0];
        exp_q.push_back({last, d});
    endfunction

    // Reference ramp: walks the shape with plain integers and queues n beats.
    function automatic void pushRamp(input int s, input int e, input int inc,
                                     input bit m, input int n);
        int  step;
        int  val;
        int  nxt;
        bit  down;
        bit  last;
        bit  tri_shape;
        step      = (inc == 0) ? 1 : inc;
        tri_shape = m && TRI_EN;
        val       = s;
        down      = 1'b0;
        for (int k = 0; k < n; k++) begin
            last = 1'b0;
            if (!down) begin
                if (val + step > e) begin
                    if (!tri_shape || (val - step <= s)) begin
                        last = 1'b1;
                        nxt  = s;
                    end else begin
                        down = 1'b1;
                        nxt  = val - step;
                    end
                end else begin
                    nxt = val + step;
                end
            end else begin
                if (val - step <= s) begin
                    last = 1'b1;
                    down = 1'b0;
                    nxt  = s;
                end else begin
                    nxt = val - step;
                end
            end
            pushExp(val, last);
            val = nxt;
        end
    endfunction

    // Monitor: compare every accepted beat against the queue and check stall stability.
    always @(negedge clk) begin
        logic [16:0] e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && tvalid) begin
                checkOutput("holdData", tdata, hold_data);
                checkOutput("holdLast", {31'd0, tlast}, {31'd0, hold_last});
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("extraBeat", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("beatData", tdata, {16'h0, e[15:0]});
                    checkOutput("beatLast", {31'd0, tlast}, {31'd0, e[16]});
                end
            end
            stall_prev = tvalid && !tready;
            hold_data  = tdata;
            hold_last  = tlast;
        end
    end

    // Starts a ramp (expectations already queued), drains it, then aborts back to IDLE.
    task automatic applyStimulus(input logic [15:0] s, input logic [15:0] e,
                                 input logic [15:0] inc, input logic m,
                                 input bit rand_ready, input bit cfg_poke);
        int budget;
        cfg_start = s;
        cfg_end   = e;
        cfg_inc   = inc;
        mode      = m;
        tready    = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        checkOutput("idleValid", {31'd0, tvalid}, 32'd0);
        en = 1'b1;
        @(posedge clk); #1;
        checkOutput("startValid", {31'd0, tvalid}, 32'd1);
        checkOutput("startData", tdata, {16'h0, s});
        if (cfg_poke) begin
            cfg_start = 16'h0003;
            cfg_end   = 16'h0009;
            cfg_inc   = 16'h0001;
            mode      = ~m;
        end
        budget = 500;
        while (exp_q.size() > 0 && budget > 0) begin
            if (rand_ready) tready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            budget--;
        end
        checkOutput("drained", exp_q.size(), 32'd0);
        exp_q.delete();
        en     = 1'b0;
        tready = 1'b0;
        @(posedge clk); #1;
        checkOutput("abortValid", {31'd0, tvalid}, 32'd0);
        checkOutput("abortLast", {31'd0, tlast}, 32'd0);
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        mode      = 1'b0;
        cfg_start = 16'h0;
        cfg_end   = 16'h0;
        cfg_inc   = 16'h0;
        tready    = 1'b0;
        #2;
        checkOutput("rstValid", {31'd0, tvalid}, 32'd0);
        checkOutput("rstData", tdata, 32'd0);
        checkOutput("rstLast", {31'd0, tlast}, 32'd0);
        @(negedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] sawtooth basic with config changes while running");
        pushExp(10, 0); pushExp(20, 0); pushExp(30, 0); pushExp(40, 1);
        pushExp(10, 0); pushExp(20, 0); pushExp(30, 0); pushExp(40, 1);
        applyStimulus(16'd10, 16'd40, 16'd10, 1'b0, 1'b0, 1'b1);

        $display("[TB] triangle 0..30 step 10");
        pushRamp(0, 30, 10, 1'b1, 8);
        applyStimulus(16'd0, 16'd30, 16'd10, 1'b1, 1'b0, 1'b0);

        $display("[TB] triangle 0..10 step 10");
        pushRamp(0, 10, 10, 1'b1, 4);
        applyStimulus(16'd0, 16'd10, 16'd10, 1'b1, 1'b0, 1'b0);

        $display("[TB] overflow guard near 0xFFFF");
        for (int k = 0; k < 4; k++) pushExp(32'hFFF0, 1);
        applyStimulus(16'hFFF0, 16'hFFFF, 16'h8000, 1'b0, 1'b0, 1'b0);

        $display("[TB] zero increment treated as one");
        pushExp(5, 0); pushExp(6, 0); pushExp(7, 1);
        pushExp(5, 0); pushExp(6, 0); pushExp(7, 1);
        applyStimulus(16'd5, 16'd7, 16'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] degenerate end below start");
        for (int k = 0; k < 3; k++) pushExp(100, 1);
        applyStimulus(16'd100, 16'd50, 16'd3, 1'b1, 1'b0, 1'b0);

        $display("[TB] sawtooth under random backpressure");
        pushRamp(10, 40, 10, 1'b0, 12);
        applyStimulus(16'd10, 16'd40, 16'd10, 1'b0, 1'b1, 1'b0);

        $display("[TB] abort while stalled");
        cfg_start = 16'd1000;
        cfg_end   = 16'd2000;
        cfg_inc   = 16'd100;
        mode      = 1'b0;
        tready    = 1'b0;
        en        = 1'b1;
        @(posedge clk); #1;
        checkOutput("stallValid", {31'd0, tvalid}, 32'd1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        checkOutput("stallData", tdata, 32'd1000);
        en = 1'b0;
        @(posedge clk); #1;
        checkOutput("dropValid", {31'd0, tvalid}, 32'd0);
        checkOutput("dropLast", {31'd0, tlast}, 32'd0);

        $display("[TB] re-enable with new config");
        pushExp(7, 0); pushExp(15, 0); pushExp(23, 0); pushExp(31, 1);
        pushExp(7, 0); pushExp(15, 0);
        applyStimulus(16'd7, 16'd31, 16'd8, 1'b0, 1'b0, 1'b0);

        $display("[TB] mode 1 under random backpressure");
        pushRamp(3, 50, 9, 1'b1, 16);
        applyStimulus(16'd3, 16'd50, 16'd9, 1'b1, 1'b1, 1'b0);

        $display("[TB] asynchronous reset mid-stream");
        pushRamp(16'h1234, 16'h2000, 16'h10, 1'b0, 5);
        cfg_start = 16'h1234;
        cfg_end   = 16'h2000;
        cfg_inc   = 16'h0010;
        mode      = 1'b0;
        tready    = 1'b1;
        en        = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        checkOutput("preRstValid", {31'd0, tvalid}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("midRstValid", {31'd0, tvalid}, 32'd0);
        checkOutput("midRstData", tdata, 32'd0);
        checkOutput("midRstLast", {31'd0, tlast}, 32'd0);
        en     = 1'b0;
        tready = 1'b0;
        exp_q.delete();
        @(negedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("postRstValid", {31'd0, tvalid}, 32'd0);

        checkOutput("queueEmpty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
